// File: rtl/piso_shift_transmitter_pkg.sv
// Shared types and helpers for the parallel-in/serial-out transmitter.
package piso_shift_transmitter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Bit-count width for a modulus; WIDTH is at least 2 so $clog2 never returns 0.
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_shift_transmitter_mod_n_counter.sv
// Modulus-MOD up counter with synchronous clear, enable and terminal-count flag.
module mod_n_counter
  import piso_shift_transmitter_pkg::*;
#(
  parameter int MOD = 8,
  localparam int CW = cnt_w(MOD)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [CW-1:0] r_cnt;
  logic          w_tc;

  assign w_tc = (r_cnt == CW'(MOD - 1));
  assign o_tc = w_tc;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_tc ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/piso_shift_transmitter.sv
// Parallel-in/serial-out transmitter with valid/ready load and zero-gap word streaming.
//
// state    | meaning
// ST_IDLE  | no word in flight, outputs low, ready for a load
// ST_SHIFT | one bit per cycle on sout; reload allowed on the final bit
module piso_shift_transmitter
  import piso_shift_transmitter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             last,
  output logic             busy
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic             w_tc;
  logic             w_shifting;
  logic             w_accept;

  assign w_shifting = (r_state == ST_SHIFT);
  assign load_ready = !w_shifting || w_tc;
  assign w_accept   = load_valid && load_ready;

  // Clearing on accept restarts the count for a streamed word; otherwise it wraps at WIDTH-1.
  mod_n_counter #(.MOD(WIDTH)) u_bit_cnt (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_clr   (w_accept || !w_shifting),
    .i_en    (w_shifting),
    .o_tc    (w_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_shreg <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shreg <= w_shreg_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    if (w_accept) begin
      w_state_nxt = ST_SHIFT;
      w_shreg_nxt = din;
    end else if (w_shifting) begin
      if (w_tc) w_state_nxt = ST_IDLE;
      w_shreg_nxt = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0} : {1'b0, r_shreg[WIDTH-1:1]};
    end
  end

  assign sout_valid = w_shifting;
  assign busy       = w_shifting;
  assign last       = w_shifting && w_tc;
  assign sout       = w_shifting && (MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0]);

endmodule

// File: tb/tb_piso_shift_transmitter.sv
// Self-checking bench: MSB-first and LSB-first instances share stimulus; a DFF-chain scoreboard rebuilds each word.
module tb_piso_shift_transmitter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       load_valid;

  logic ready_m, sout_m, v_m, last_m, busy_m;
  logic ready_l, sout_l, v_l, last_l, busy_l;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  int         rd[2];
  int         nbits[2];
  logic [7:0] acc[2];

  always #5 clk = ~clk;

  piso_shift_transmitter #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .din(din), .load_valid(load_valid), .load_ready(ready_m),
    .sout(sout_m), .sout_valid(v_m), .last(last_m), .busy(busy_m)
  );

  piso_shift_transmitter #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .din(din), .load_valid(load_valid), .load_ready(ready_l),
    .sout(sout_l), .sout_valid(v_l), .last(last_l), .busy(busy_l)
  );

  // Receive side: one DFF chain per instance, compared against accepted words on 'last'.
  task automatic sb_sample();
    logic s, v, l, b;
    logic [7:0] a;
    for (int d = 0; d < 2; d++) begin
      s = (d == 0) ? sout_m : sout_l;
      v = (d == 0) ? v_m    : v_l;
      l = (d == 0) ? last_m : last_l;
      b = (d == 0) ? busy_m : busy_l;
      total++;
      if (b !== v) begin
        bad++;
        $display("FAIL sb_busy dut%0d: got %b want %b", d, b, v);
      end
      if (!rst_n) begin
        nbits[d] = 0;
        total++;
        if (v !== 1'b0) begin
          bad++;
          $display("FAIL sb_reset_valid dut%0d: got %b want 0", d, v);
        end
      end else if (v === 1'b1) begin
        a = acc[d];
        a = (d == 0) ? {a[6:0], s} : {s, a[7:1]};
        acc[d] = a;
        nbits[d]++;
        total++;
        if (l === 1'b1) begin
          if (nbits[d] != 8) begin
            bad++;
            $display("FAIL sb_last_pos dut%0d: got bit %0d want bit 8", d, nbits[d]);
          end
          total++;
          if (rd[d] >= exp_q.size()) begin
            bad++;
            $display("FAIL sb_word dut%0d: got %h want no word", d, a);
          end else if (a !== exp_q[rd[d]]) begin
            bad++;
            $display("FAIL sb_word dut%0d: got %h want %h", d, a, exp_q[rd[d]]);
          end
          rd[d]++;
          nbits[d] = 0;
        end else if (nbits[d] >= 8) begin
          bad++;
          $display("FAIL sb_missing_last dut%0d: got %0d bits want last on 8", d, nbits[d]);
        end
      end else begin
        total++;
        if (s !== 1'b0 || l !== 1'b0 || nbits[d] != 0) begin
          bad++;
          $display("FAIL sb_idle dut%0d: got sout=%b last=%b partial=%0d want 0/0/0", d, s, l, nbits[d]);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    sb_sample();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    load_valid = 1'b1;
    din = 8'h5A;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if ({v_m, sout_m, last_m, v_l, sout_l, last_l} !== 6'b0) begin
        bad++;
        $display("FAIL reset_outputs: got %b want 000000", {v_m, sout_m, last_m, v_l, sout_l, last_l});
      end
    end
    rst_n = 1'b1;
    load_valid = 1'b0;
    tick();
    total++;
    if (ready_m !== 1'b1 || ready_l !== 1'b1 || v_m !== 1'b0 || v_l !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got ready=%b%b valid=%b%b want 11/00", ready_m, ready_l, v_m, v_l);
    end
  endtask

  task automatic test_single(input logic [7:0] w);
    din = w;
    load_valid = 1'b1;
    exp_q.push_back(w);
    tick();
    load_valid = 1'b0;
    din = 8'h00;
    for (int k = 0; k < 8; k++) begin
      total++;
      if (v_m !== 1'b1 || v_l !== 1'b1 || sout_m !== w[7-k] || sout_l !== w[k]
          || last_m !== (k == 7) || last_l !== (k == 7)
          || ready_m !== (k == 7) || ready_l !== (k == 7)) begin
        bad++;
        $display("FAIL single_bit%0d w=%h: got v=%b%b s=%b%b last=%b%b rdy=%b%b want v=11 s=%b%b last=%0d rdy=%0d",
                 k, w, v_m, v_l, sout_m, sout_l, last_m, last_l, ready_m, ready_l, w[7-k], w[k], k == 7, k == 7);
      end
      tick();
    end
    total++;
    if (v_m !== 1'b0 || v_l !== 1'b0 || ready_m !== 1'b1 || ready_l !== 1'b1) begin
      bad++;
      $display("FAIL single_idle w=%h: got v=%b%b rdy=%b%b want 00/11", w, v_m, v_l, ready_m, ready_l);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] stream;
    logic [15:0] want;
    want = 16'b1111000000001111;
    din = 8'hF0;
    load_valid = 1'b1;
    exp_q.push_back(8'hF0);
    tick();
    din = 8'h0F;
    for (int k = 0; k < 16; k++) begin
      stream[15-k] = sout_m;
      total++;
      if (v_m !== 1'b1 || v_l !== 1'b1 || ready_m !== ((k % 8) == 7) || last_m !== ((k % 8) == 7)) begin
        bad++;
        $display("FAIL b2b_cycle%0d: got v=%b%b rdy=%b last=%b want v=11 rdy=%0d last=%0d",
                 k, v_m, v_l, ready_m, last_m, (k % 8) == 7, (k % 8) == 7);
      end
      if (k == 7) exp_q.push_back(8'h0F);
      tick();
      if (k == 7) load_valid = 1'b0;
    end
    total++;
    if (stream !== want) begin
      bad++;
      $display("FAIL b2b_stream: got %b want %b", stream, want);
    end
    total++;
    if (v_m !== 1'b0 || v_l !== 1'b0) begin
      bad++;
      $display("FAIL b2b_idle: got v=%b%b want 00", v_m, v_l);
    end
  endtask

  task automatic test_ignore_busy();
    logic [7:0] w;
    w = 8'h3C;
    din = w;
    load_valid = 1'b1;
    exp_q.push_back(w);
    tick();
    load_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      total++;
      if (ready_m !== (k == 7) || ready_l !== (k == 7) || sout_m !== w[7-k] || sout_l !== w[k]) begin
        bad++;
        $display("FAIL ignore_bit%0d: got rdy=%b%b s=%b%b want rdy=%0d s=%b%b",
                 k, ready_m, ready_l, sout_m, sout_l, k == 7, w[7-k], w[k]);
      end
      load_valid = (k >= 1 && k <= 5);
      din = 8'hFF;
      tick();
    end
    load_valid = 1'b0;
    total++;
    if (v_m !== 1'b0 || v_l !== 1'b0) begin
      bad++;
      $display("FAIL ignore_idle: got v=%b%b want 00", v_m, v_l);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] w;
    w = 8'hC3;
    din = w;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (v_m !== 1'b1 || sout_m !== w[7-k] || sout_l !== w[k]) begin
        bad++;
        $display("FAIL abort_bit%0d: got v=%b s=%b%b want v=1 s=%b%b", k, v_m, sout_m, sout_l, w[7-k], w[k]);
      end
      if (k == 2) rst_n = 1'b0;
      tick();
    end
    total++;
    if ({v_m, sout_m, last_m, v_l, sout_l, last_l} !== 6'b0) begin
      bad++;
      $display("FAIL abort_outputs: got %b want 000000", {v_m, sout_m, last_m, v_l, sout_l, last_l});
    end
    rst_n = 1'b1;
    tick();
    total++;
    if (v_m !== 1'b0 || v_l !== 1'b0 || ready_m !== 1'b1) begin
      bad++;
      $display("FAIL abort_residual: got v=%b%b rdy=%b want 00/1", v_m, v_l, ready_m);
    end
    test_single(8'h96);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    din = 8'h00;
    load_valid = 1'b0;
    rd[0] = 0; rd[1] = 0;
    nbits[0] = 0; nbits[1] = 0;
    acc[0] = 8'h00; acc[1] = 8'h00;

    test_reset();
    test_single(8'hA5);
    test_single(8'h01);
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid_word();
    tick();
    tick();

    for (int d = 0; d < 2; d++) begin
      total++;
      if (rd[d] != exp_q.size()) begin
        bad++;
        $display("FAIL sb_drain dut%0d: got %0d words want %0d", d, rd[d], exp_q.size());
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
